// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a byte stream (high byte first) into 16-bit words written
// to program memory from address 0, then releases the CPU. Define PROG_LOADER_CHKSUM_EN for a trailing checksum byte.
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               pm_we,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic [INSTR_W-1:0] pm_wdata,
    output logic               cpu_run,
    output logic               busy,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_RUN, S_ERR, S_CHK
    } state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] len_q;
    logic [7:0]      hi_q;
    logic            xfer;
    logic            last_word;
    logic            restart;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]      sum_q;
`endif

    assign xfer      = in_valid && in_ready;
    assign last_word = (words_loaded + (ADDR_W+1)'(1)) == len_q;
    assign restart   = start && (state == S_IDLE || state == S_RUN || state == S_ERR);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RUN, S_ERR: if (start) state_nxt = S_LEN;
            S_LEN: if (xfer) state_nxt = S_HI;
            S_HI:  if (xfer) state_nxt = S_LO;
            S_LO:  if (xfer) state_nxt = S_WR;
            S_WR: begin
`ifdef PROG_LOADER_CHKSUM_EN
                state_nxt = last_word ? S_CHK : S_HI;
`else
                state_nxt = last_word ? S_RUN : S_HI;
`endif
            end
`ifdef PROG_LOADER_CHKSUM_EN
            S_CHK: if (xfer) state_nxt = (in_data == sum_q) ? S_RUN : S_ERR;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        pm_we    = 1'b0;
        cpu_run  = 1'b0;
        busy     = 1'b0;
        error    = 1'b0;
        case (state)
            S_LEN, S_HI, S_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WR: begin
                pm_we = 1'b1;
                busy  = 1'b1;
            end
            S_RUN: cpu_run = 1'b1;
`ifdef PROG_LOADER_CHKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_ERR: error = 1'b1;
`endif
            default: ;
        endcase
    end

    // A length byte of 0 encodes a full-depth load of 2^ADDR_W words.
    always_ff @(posedge clk) begin
        if (rst) begin
            pm_addr      <= '0;
            pm_wdata     <= '0;
            words_loaded <= '0;
            len_q        <= '0;
            hi_q         <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            if (restart) begin
                pm_addr      <= '0;
                words_loaded <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
                sum_q        <= '0;
`endif
            end
            case (state)
                S_LEN: if (xfer) len_q <= (in_data == 8'd0) ? (ADDR_W+1)'(2**ADDR_W)
                                                            : (ADDR_W+1)'(in_data);
                S_HI: if (xfer) begin
                    hi_q <= in_data;
`ifdef PROG_LOADER_CHKSUM_EN
                    sum_q <= sum_q + in_data;
`endif
                end
                S_LO: if (xfer) begin
                    pm_wdata <= INSTR_W'({hi_q, in_data});
`ifdef PROG_LOADER_CHKSUM_EN
                    sum_q <= sum_q + in_data;
`endif
                end
                S_WR: begin
                    pm_addr      <= pm_addr + ADDR_W'(1);
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: cycle vector table, hand-written corner sequences,
// and randomized loads checked against a byte-list reference model.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               pm_we;
    logic [ADDR_W-1:0]  pm_addr;
    logic [INSTR_W-1:0] pm_wdata;
    logic               cpu_run;
    logic               busy;
    logic               error;
    logic [ADDR_W:0]    words_loaded;

    prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .cpu_run(cpu_run), .busy(busy), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } wr_t;
    wr_t wr_q[$];

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  data;
        logic [3:0]  flags;   // {in_ready, pm_we, cpu_run, busy}
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [8:0]  wl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture every program-memory write; in_ready must be low in the write cycle.
    always @(negedge clk) begin
        if (!rst && pm_we) begin
            wr_q.push_back('{pm_addr, pm_wdata});
            check("ready_low_in_wr", 32'(in_ready), 32'd0);
        end
    end

    // Reference model: derived directly from the byte list.
    function automatic int n_words(input bq_t b);
        return (b[0] == 8'd0) ? 256 : int'(b[0]);
    endfunction

    function automatic logic [15:0] word_of(input bq_t b, input int i);
        return {b[1 + 2*i], b[2 + 2*i]};
    endfunction

    function automatic logic [7:0] chk_of(input bq_t b);
        logic [7:0] s = 8'd0;
        for (int i = 1; i <= 2 * n_words(b); i++) s = s + b[i];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
        step();
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin
                in_data = 8'($urandom);
                step();
                check("gap_no_we", 32'(pm_we), 32'd0);
            end
        end
    endtask

    task automatic run_load(input bq_t b, input int gap, input int glitch_at, input bit bad_sum);
        int         n;
        int         nw;
        bit         exp_ok;
        bq_t        s;
        logic [7:0] sum_byte;
        s        = b;
        nw       = n_words(b);
        sum_byte = chk_of(b) + (bad_sum ? 8'd1 : 8'd0);
        exp_ok   = 1'b1;
`ifdef PROG_LOADER_CHKSUM_EN
        s.push_back(sum_byte);
        exp_ok = !bad_sum;
`endif
        wr_q.delete();
        in_valid = 1'b0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("enter_len", 32'({in_ready, busy, cpu_run}), 32'b110);
        for (int i = 0; i < s.size(); i++) begin
            if (i == glitch_at) begin
                in_valid = 1'b0;
                start    = 1'b1;
                step();
                start    = 1'b0;
                check("start_ignored", 32'({busy, in_ready, cpu_run}), 32'b110);
            end
            send_byte(s[i], gap);
        end
        in_valid = 1'b0;
        n = 0;
        while (!(cpu_run || error) && n < 10) begin
            step();
            n++;
        end
        check("load_end", 32'({cpu_run, error, busy}), exp_ok ? 32'b100 : 32'b010);
        check("wr_count", 32'(wr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            check("wr_addr", 32'(wr_q[i].addr), 32'(i));
            check("wr_data", 32'(wr_q[i].data), 32'(word_of(b, i)));
        end
        check("words_loaded", 32'(words_loaded), 32'(nw));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        bq_t  q;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) step();
        check("reset_flags", 32'({in_ready, pm_we, cpu_run, busy, error}), 32'd0);
        check("reset_regs", 32'({pm_addr, pm_wdata}), 32'd0);
        check("reset_wl", 32'(words_loaded), 32'd0);
        rst = 1'b0;

`ifndef PROG_LOADER_CHKSUM_EN
        // Cycle-exact walk of 0x02,0x12,0x34,0xAB,0xCD with in_valid held high.
        vecs[0] = '{1'b1, 1'b0, 8'h00, 4'b1001, 8'd0, 16'h0000, 9'd0};
        vecs[1] = '{1'b0, 1'b1, 8'h02, 4'b1001, 8'd0, 16'h0000, 9'd0};
        vecs[2] = '{1'b0, 1'b1, 8'h12, 4'b1001, 8'd0, 16'h0000, 9'd0};
        vecs[3] = '{1'b0, 1'b1, 8'h34, 4'b0101, 8'd0, 16'h1234, 9'd0};
        vecs[4] = '{1'b0, 1'b1, 8'hAB, 4'b1001, 8'd1, 16'h1234, 9'd1};
        vecs[5] = '{1'b0, 1'b1, 8'hAB, 4'b1001, 8'd1, 16'h1234, 9'd1};
        vecs[6] = '{1'b0, 1'b1, 8'hCD, 4'b0101, 8'd1, 16'hABCD, 9'd1};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 4'b0010, 8'd2, 16'hABCD, 9'd2};
        vecs[8] = '{1'b0, 1'b1, 8'hFF, 4'b0010, 8'd2, 16'hABCD, 9'd2};
        for (int i = 0; i < 9; i++) begin
            start = vecs[i].st; in_valid = vecs[i].vld; in_data = vecs[i].data;
            step();
            check($sformatf("vec%0d_flags", i), 32'({in_ready, pm_we, cpu_run, busy}), 32'(vecs[i].flags));
            check($sformatf("vec%0d_addr", i), 32'(pm_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_wdata", i), 32'(pm_wdata), 32'(vecs[i].wdata));
            check($sformatf("vec%0d_wl", i), 32'(words_loaded), 32'(vecs[i].wl));
        end
        start = 1'b0; in_valid = 1'b0;
`endif

        // Gapped stream: identical writes, state holds while in_valid is low.
        q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        run_load(q, 3, -1, 1'b0);

        // start in RUN drops cpu_run on the next cycle and re-enters LEN.
        start = 1'b1;
        step();
        start = 1'b0;
        check("run_restart", 32'({cpu_run, busy, in_ready}), 32'b011);
        check("run_restart_wl", 32'(words_loaded), 32'd0);

        // start pulses during HI and after a WR are ignored.
        run_load(q, 0, 1, 1'b0);
        run_load(q, 0, 3, 1'b0);

        // Full-depth load: length byte 0 means 256 words.
        q = '{8'h00};
        for (int i = 0; i < 512; i++) q.push_back(8'($urandom));
        run_load(q, 0, -1, 1'b0);
        check("full_addr_wrap", 32'(pm_addr), 32'd0);

        // Reset in the middle of word 1 of a 3-word load.
        wr_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_flags", 32'({in_ready, pm_we, cpu_run, busy, error}), 32'd0);
        check("midrst_regs", 32'({pm_addr, pm_wdata}), 32'd0);
        check("midrst_wl", 32'(words_loaded), 32'd0);
        check("midrst_kept_word0", 32'({wr_q[0].addr, wr_q[0].data}), 32'h0_1122);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        check("idle_valid_ignored", 32'({in_ready, busy, cpu_run, pm_we}), 32'd0);
        in_valid = 1'b0;
        q = '{8'h01, 8'h55, 8'hAA};
        run_load(q, 0, -1, 1'b0);

`ifdef PROG_LOADER_CHKSUM_EN
        // Explicit checksum cases: 0x10+0x20 = 0x30 matches, 0x31 does not.
        q = '{8'h01, 8'h10, 8'h20, 8'h30};
        start = 1'b1; step(); start = 1'b0;
        foreach (q[i]) send_byte(q[i], 0);
        in_valid = 1'b0;
        step();
        check("chk_match", 32'({cpu_run, error}), 32'b10);
        q = '{8'h01, 8'h10, 8'h20, 8'h31};
        start = 1'b1; step(); start = 1'b0;
        foreach (q[i]) send_byte(q[i], 0);
        in_valid = 1'b0;
        step();
        check("chk_mismatch", 32'({cpu_run, error, busy}), 32'b010);
        start = 1'b1; step(); start = 1'b0;
        check("err_restart", 32'({error, in_ready, busy}), 32'b011);
`endif

        // Randomized loads against the model.
        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = int'($urandom_range(1, 6));
            q = '{8'(nw)};
            for (int i = 0; i < 2 * nw; i++) q.push_back(8'($urandom));
            run_load(q, int'($urandom_range(0, 2)), int'($urandom_range(0, 2 * nw + 1)) - 1,
                     1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader directly upstream of the 3-stage processor's program memory.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes each word into program memory at consecutive addresses from 0.
- Holds the processor stalled until the load completes, then releases it via cpu_run.

Parameters:
ADDR_W, 8, program memory address width; depth is 2^ADDR_W words
INSTR_W, 16, instruction word width; fixed at 2 bytes

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to begin a load; honoured only in IDLE, RUN, ERR
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle
pm_we  output  1  program memory write strobe, one cycle per word
pm_addr  output  ADDR_W  program memory write address
pm_wdata  output  INSTR_W  program memory write data
cpu_run  output  1  processor enable (gates PC increment and pipeline advance)
busy  output  1  high in LEN, HI, LO, WR, CHK
error  output  1  high in ERR
words_loaded  output  ADDR_W+1  count of words written in current or last load

Behaviour:
- Reset: state IDLE; all outputs 0; internal address, count, and checksum cleared. Program memory contents are not cleared.
- Reset mid-load: abort to IDLE on the next edge. Words already written stay in memory. cpu_run stays 0.
- A byte transfers on an edge where in_valid and in_ready are both 1. in_ready is 1 only in LEN, HI, LO, CHK. in_data is ignored when no transfer occurs.
- FSM:
  - IDLE: start -> LEN, clear words_loaded and pm_addr.
  - LEN: transfer -> latch N = in_data, with 0 meaning 2^ADDR_W words; -> HI.
  - HI: transfer -> latch upper byte; -> LO.
  - LO: transfer -> latch lower byte; -> WR.
  - WR: single cycle; pm_we=1; pm_wdata={hi,lo}; pm_addr=current address; in_ready=0. On the following edge, address and words_loaded increment. If words_loaded+1 == N -> CHK when PROG_LOADER_CHKSUM_EN is defined, else RUN. Otherwise -> HI.
  - RUN: cpu_run=1. start -> LEN, with cpu_run=0 from that edge.
  - ERR: error=1, cpu_run=0. start -> LEN.
- Latency: pm_we is asserted exactly 1 cycle after the LO transfer edge. cpu_run rises the cycle after the final WR cycle.
- start is ignored in LEN, HI, LO, WR, CHK; a load cannot be restarted mid-stream except by rst.
- pm_addr wraps to 0 after 2^ADDR_W-1. This is only reachable at the N=0 (full-depth) load end, where it is harmless.
- pm_addr and pm_wdata hold their last values outside WR; only pm_we qualifies them.
- in_valid with no start while in IDLE/RUN/ERR: no transfer, no effect.

Optional Feature:
- Macro PROG_LOADER_CHKSUM_EN.
- When defined:
  - an 8-bit running sum (mod 256) of all instruction bytes, excluding the length byte, is kept;
  - state CHK accepts one trailing byte;
  - a match goes to RUN, a mismatch goes to ERR;
  - the sum is cleared on entry to LEN.
- When undefined: no CHK state, no trailing byte; the final WR goes straight to RUN and the error output is tied 0.

Test Plan:
- Reset then stream 0x02, 0x12, 0x34, 0xAB, 0xCD with in_valid held high. Expect:
  - pm_we pulses with addr 0 / data 0x1234, then addr 1 / data 0xABCD;
  - words_loaded=2;
  - cpu_run=1 one cycle after the second WR;
  - in_ready=0 during each WR.
- Same stream with in_valid deasserted for 3 cycles between bytes. Expect identical writes, no spurious pm_we, and state holds while in_valid=0.
- Length byte 0x00 followed by 512 bytes. Expect 256 writes at addr 0..255, words_loaded=256, then RUN.
- Assert rst after the HI byte of word 1 in a 3-word load. Expect:
  - IDLE next cycle, all outputs 0;
  - a subsequent start plus a full 0x01, 0x55, 0xAA load writes 0x55AA at addr 0.
- Pulse start during HI of a load. Expect it ignored and the load completes normally. Pulse start in RUN: cpu_run drops the next cycle, state LEN.
- With PROG_LOADER_CHKSUM_EN, stream 0x01, 0x10, 0x20, then 0x30. Expect RUN. Repeat with trailing 0x31: expect ERR, error=1, cpu_run=0.
